maxpool_stream_ctrl: RTL and testbench
======================================

Name: maxpool_stream_ctrl

Overview:
- Frame-level sequencer for the Line_buffer_2x2 -> MaxPool2d pooling datapath.
- Accepts one frame of raster-order pixels from an upstream valid/ready source and drives the line buffer's in_valid.
- Tracks row/column position and issues a pool-fire strobe at every stride-2 window position (odd row, odd column).
- Stalls the whole pipeline on downstream backpressure and reports frame completion.

Parameters:
- dataColNum, 28, pixels per row (>= 2)
- dataRowNum, 28, rows per frame (>= 2)
- COL_W, $clog2(dataColNum), column counter width
- ROW_W, $clog2(dataRowNum), row counter width

Ports:
- clk  in  1  system clock, rising edge
- irst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame when idle
- src_valid  in  1  upstream pixel valid
- src_ready  out  1  upstream pixel ready (combinational)
- dst_ready  in  1  downstream (pool consumer) ready
- lb_in_valid  out  1  line buffer in_valid; high exactly on accepted pixels (combinational)
- pool_fire  out  1  registered; window complete, MaxPool2d result valid this cycle
- out_last  out  1  registered; coincides with the final pool_fire of the frame
- col_idx  out  COL_W  column of the next pixel to accept
- row_idx  out  ROW_W  row of the next pixel to accept
- busy  out  1  high in RUN or FLUSH
- frame_done  out  1  one-cycle pulse after the final pool_fire

Behaviour:
- Reset (async, irst_n=0): state=IDLE. col_idx, row_idx, pool_fire, out_last, frame_done and busy all 0. src_ready=0 and lb_in_valid=0 follow from state.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start -> RUN. Counters are cleared on entry to RUN.
  - RUN: src_ready = dst_ready. accept = src_valid & src_ready. lb_in_valid = accept.
  - RUN, on accept: col_idx increments; at dataColNum-1 it wraps to 0 and row_idx increments.
  - RUN -> FLUSH on accepting the pixel at (dataRowNum-1, dataColNum-1).
  - FLUSH: src_ready=0. Lasts one cycle, during which the registered pool_fire/out_last for the last window is visible. -> DONE.
  - DONE: frame_done=1 for one cycle. -> IDLE.
- Fire rule: pool_fire is registered, high the cycle after an accept at row_idx[0]=1, col_idx[0]=1, row_idx <= 2*(dataRowNum/2)-1 and col_idx <= 2*(dataColNum/2)-1. Latency 1 matches the line buffer's registered window output.
- Odd dimensions: the trailing row and column are accepted but never fire (floor pooling).
- Fires per frame = (dataRowNum/2)*(dataColNum/2). out_last is high with the fire at window (last even-aligned row, last even-aligned col).
- Stall: dst_ready=0 drops src_ready in the same cycle. No pixel is accepted and counters hold. A pending registered pool_fire still completes, since it was issued before the stall.
- start while busy, in DONE, or coincident with reset: ignored.
- Reset mid-frame: everything is cleared asynchronously; a partial frame is discarded and no frame_done is issued.
- src_valid in IDLE is not accepted.

Optional Feature:
- Macro MAXPOOL_STREAM_CTRL_PERF_EN.
- Defined: adds output stall_cycles (32 bits), cleared on entry to RUN. It increments every RUN cycle with src_valid=1 and dst_ready=0, saturates at all-ones, and holds its value after the frame.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package maxpool_pkg: state enum (IDLE, RUN, FLUSH, DONE); default frame dimensions; a width helper for the counters; a fires-per-frame constant function.
- One sub-module, raster_pos_counter: column/row counter with enable, column wrap, row increment and last-pixel flag. The FSM and fire logic stay in the top module.

Test Plan:
- 4x4 frame, src_valid=1, dst_ready=1, start pulse -> 16 accepts in 16 cycles; pool_fire at the cycles after accepts 5, 7, 13 and 15; out_last with the 4th fire; frame_done one cycle later; busy low afterwards.
- 5x5 frame -> 25 accepts, exactly 4 fires, at the cycles after accepts 6, 8, 16 and 18; no fire on row 4 or column 4.
- 4x4 with dst_ready=0 for 3 cycles after accept 5 -> src_ready low those 3 cycles, counters frozen; the fire from accept 5 still appears; 4 fires total; with PERF_EN, stall_cycles=3.
- src_valid toggled 1010... in a 4x4 frame -> accepts only on valid cycles; fire positions unchanged relative to accept count; frame_done after the 16th accept + 2 cycles.
- irst_n pulsed low after accept 9 -> all outputs 0 immediately, no frame_done. A new start runs a clean 4-fire frame.
- start re-pulsed mid-frame -> ignored; counters are not cleared and the frame finishes normally.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2/stride-2 max-pool stream sequencer.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_COL_NUM = 28;
    localparam int DEF_ROW_NUM = 28;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Floor pooling: a trailing odd row/column never forms a window.
    function automatic int fires_per_frame(input int rows, input int cols);
        return (rows / 2) * (cols / 2);
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Raster-order column/row position counter with column wrap and last-pixel flag.
module raster_pos_counter #(
    parameter int COL_NUM = 28,
    parameter int ROW_NUM = 28,
    parameter int COL_W   = 5,
    parameter int ROW_W   = 5
) (
    input  logic             clk,
    input  logic             irst_n,
    input  logic             clear,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pix
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_NUM - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_NUM - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // Position registers: clear on frame start, advance one pixel per enable.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (clear) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (en) begin
            if (col_r == COL_MAX) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    assign col      = col_r;
    assign row      = row_r;
    assign last_pix = (col_r == COL_MAX) && (row_r == ROW_MAX);

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Frame sequencer for the Line_buffer_2x2 -> MaxPool2d datapath.
// Optional stall counter port enabled by MAXPOOL_STREAM_CTRL_PERF_EN.
module maxpool_stream_ctrl
    import maxpool_pkg::*;
#(
    parameter int dataColNum = DEF_COL_NUM,
    parameter int dataRowNum = DEF_ROW_NUM,
    parameter int COL_W      = cnt_width(dataColNum),
    parameter int ROW_W      = cnt_width(dataRowNum)
) (
    input  logic             clk,
    input  logic             irst_n,
    input  logic             start,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             dst_ready,
    output logic             lb_in_valid,
    output logic             pool_fire,
    output logic             out_last,
    output logic [COL_W-1:0] col_idx,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             frame_done
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    // Last even-aligned coordinates; anything beyond is the unpooled odd tail.
    localparam logic [COL_W-1:0] COL_FIRE_MAX = COL_W'(2 * (dataColNum / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_FIRE_MAX = ROW_W'(2 * (dataRowNum / 2) - 1);

    state_e state_r;
    state_e state_s;
    logic   accept_s;
    logic   start_run_s;
    logic   last_pix_s;
    logic   fire_pos_s;
    logic   last_win_s;

    raster_pos_counter #(
        .COL_NUM (dataColNum),
        .ROW_NUM (dataRowNum),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_pos (
        .clk      (clk),
        .irst_n   (irst_n),
        .clear    (start_run_s),
        .en       (accept_s),
        .col      (col_idx),
        .row      (row_idx),
        .last_pix (last_pix_s)
    );

    // State register.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (accept_s && last_pix_s) state_s = FLUSH;
                else                        state_s = RUN;
            end
            FLUSH:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake and window-position decode.
    always_comb begin
        src_ready = 1'b0;
        case (state_r)
            RUN:     src_ready = dst_ready;
            default: src_ready = 1'b0;
        endcase
        accept_s    = src_valid & src_ready;
        lb_in_valid = accept_s;
        start_run_s = (state_r == IDLE) & start;
        fire_pos_s  = row_idx[0] & col_idx[0] &
                      (row_idx <= ROW_FIRE_MAX) & (col_idx <= COL_FIRE_MAX);
        last_win_s  = (row_idx == ROW_FIRE_MAX) & (col_idx == COL_FIRE_MAX);
    end

    // Registered status; fire lags the accept by one to align with the line buffer window.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            pool_fire  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pool_fire  <= accept_s & fire_pos_s;
            out_last   <= accept_s & fire_pos_s & last_win_s;
            busy       <= (state_s == RUN) || (state_s == FLUSH);
            frame_done <= (state_r == FLUSH);
        end
    end

`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where upstream had data but downstream blocked.
    always_ff @(posedge clk or negedge irst_n) begin
        if (!irst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (start_run_s) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == RUN) && src_valid && !dst_ready &&
                     (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl: a 4x4 and a 5x5 instance on one clock.
module tb_maxpool_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic irst_n, start4, start5, src_valid, dst_ready, sel5;
    logic rdy4, lb4, pf4, ol4, busy4, fd4;
    logic rdy5, lb5, pf5, ol5, busy5, fd5;
    logic [1:0] col4, row4;
    logic [2:0] col5, row5;
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
    logic [31:0] sc4, sc5, s_sc;
    assign s_sc = sel5 ? sc5 : sc4;
`endif

    maxpool_stream_ctrl #(.dataColNum(4), .dataRowNum(4)) u4 (
        .clk(clk), .irst_n(irst_n), .start(start4), .src_valid(src_valid),
        .src_ready(rdy4), .dst_ready(dst_ready), .lb_in_valid(lb4),
        .pool_fire(pf4), .out_last(ol4), .col_idx(col4), .row_idx(row4),
        .busy(busy4), .frame_done(fd4)
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
        , .stall_cycles(sc4)
`endif
    );

    maxpool_stream_ctrl #(.dataColNum(5), .dataRowNum(5)) u5 (
        .clk(clk), .irst_n(irst_n), .start(start5), .src_valid(src_valid),
        .src_ready(rdy5), .dst_ready(dst_ready), .lb_in_valid(lb5),
        .pool_fire(pf5), .out_last(ol5), .col_idx(col5), .row_idx(row5),
        .busy(busy5), .frame_done(fd5)
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
        , .stall_cycles(sc5)
`endif
    );

    logic s_rdy, s_lb, s_pf, s_ol, s_busy, s_fd;
    logic [31:0] s_col, s_row;
    assign s_rdy  = sel5 ? rdy5  : rdy4;
    assign s_lb   = sel5 ? lb5   : lb4;
    assign s_pf   = sel5 ? pf5   : pf4;
    assign s_ol   = sel5 ? ol5   : ol4;
    assign s_busy = sel5 ? busy5 : busy4;
    assign s_fd   = sel5 ? fd5   : fd4;
    assign s_col  = sel5 ? 32'(col5) : 32'(col4);
    assign s_row  = sel5 ? 32'(row5) : 32'(row4);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 stall after accept 5, 2 valid toggling, 3 start re-pulse, 4 reset after accept 9
    task automatic run_frame(input int dim, input int mode,
                             input int e0, input int e1, input int e2, input int e3);
        int  n, acc, prev, fires, ol_idx, ol_cnt, fd_cnt, fd_gap, last_cyc, stall_left;
        int  fl [4];
        bit  done, restarted, run;
        n = dim * dim; acc = 0; prev = -1; fires = 0; ol_idx = -1; ol_cnt = 0;
        fd_cnt = 0; fd_gap = -1; last_cyc = 0; stall_left = 0; done = 1'b0; restarted = 1'b0;
        for (int i = 0; i < 4; i++) fl[i] = -1;
        sel5 = (dim == 5);
        @(negedge clk);
        if (sel5) start5 = 1'b1; else start4 = 1'b1;
        src_valid = 1'b1; dst_ready = 1'b1;
        #1;
        check("idle_src_ready", 32'(s_rdy), 0);
        check("idle_lb_in_valid", 32'(s_lb), 0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            start4 = 1'b0; start5 = 1'b0;
            src_valid = (mode == 2) ? ((cyc % 2) == 0) : 1'b1;
            dst_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (mode == 3 && acc == 8 && !restarted) begin
                restarted = 1'b1;
                if (sel5) start5 = 1'b1; else start4 = 1'b1;
            end
            #1;
            if (mode == 4 && acc == 10) begin
                irst_n = 1'b0;
                #1;
                check("rst_col", s_col, 0);
                check("rst_row", s_row, 0);
                check("rst_pool_fire", 32'(s_pf), 0);
                check("rst_out_last", 32'(s_ol), 0);
                check("rst_busy", 32'(s_busy), 0);
                check("rst_frame_done", 32'(s_fd), 0);
                check("rst_src_ready", 32'(s_rdy), 0);
                check("rst_lb_in_valid", 32'(s_lb), 0);
                #2 irst_n = 1'b1;
                done = 1'b1;
            end else begin
                run = (acc < n);
                check("src_ready", 32'(s_rdy), 32'(run & dst_ready));
                check("lb_in_valid", 32'(s_lb), 32'(run & src_valid & dst_ready));
                if (run) begin
                    check("col_idx", s_col, acc % dim);
                    check("row_idx", s_row, acc / dim);
                    check("busy_run", 32'(s_busy), 1);
                end
                if (s_pf) begin
                    if (fires < 4) fl[fires] = prev;
                    fires++;
                end
                if (s_ol) begin ol_idx = prev; ol_cnt++; end
                if (s_fd) begin fd_cnt++; fd_gap = cyc - last_cyc; done = 1'b1; end
                if (stall_left > 0) stall_left--;
                if (s_lb) begin
                    prev = acc; last_cyc = cyc; acc++;
                    if (mode == 1 && prev == 5) stall_left = 3;
                end else begin
                    prev = -1;
                end
            end
        end
        if (mode == 4) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk); #1;
                check("post_rst_frame_done", 32'(s_fd), 0);
                check("post_rst_busy", 32'(s_busy), 0);
            end
        end else begin
            check("accept_count", acc, n);
            check("fire_count", fires, 4);
            check("fire0_after_accept", fl[0], e0);
            check("fire1_after_accept", fl[1], e1);
            check("fire2_after_accept", fl[2], e2);
            check("fire3_after_accept", fl[3], e3);
            check("out_last_count", ol_cnt, 1);
            check("out_last_after_accept", ol_idx, e3);
            check("frame_done_count", fd_cnt, 1);
            check("frame_done_gap", fd_gap, 2);
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
            check("stall_cycles", s_sc, (mode == 1) ? 3 : 0);
`endif
            @(negedge clk); #1;
            check("busy_after", 32'(s_busy), 0);
            check("frame_done_pulse_end", 32'(s_fd), 0);
        end
    endtask

    initial begin
        irst_n = 1'b0; start4 = 1'b1; start5 = 1'b0;
        src_valid = 1'b1; dst_ready = 1'b1; sel5 = 1'b0;
        #13;
        check("reset_col", s_col, 0);
        check("reset_row", s_row, 0);
        check("reset_pool_fire", 32'(s_pf), 0);
        check("reset_out_last", 32'(s_ol), 0);
        check("reset_busy", 32'(s_busy), 0);
        check("reset_frame_done", 32'(s_fd), 0);
        check("reset_src_ready", 32'(s_rdy), 0);
        check("reset_lb_in_valid", 32'(s_lb), 0);
        @(negedge clk);
        irst_n = 1'b1; start4 = 1'b0;
        @(negedge clk); #1;
        check("start_in_reset_ignored", 32'(s_busy), 0);

        run_frame(4, 0, 5, 7, 13, 15);
        run_frame(5, 0, 6, 8, 16, 18);
        run_frame(4, 1, 5, 7, 13, 15);
        run_frame(4, 2, 5, 7, 13, 15);
        run_frame(4, 4, 0, 0, 0, 0);
        run_frame(4, 0, 5, 7, 13, 15);
        run_frame(4, 3, 5, 7, 13, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
